// File: rtl/apu_package.sv
// Shared APU constants, status-bit indices and the payload structs carried
// through the floating-point multiplier pipeline.
package apu_package;

  localparam int EXP_WIDTH     = 8;
  localparam int SIG_WIDTH     = 23;
  localparam int FP_WIDTH      = 1 + EXP_WIDTH + SIG_WIDTH;
  localparam int IEEE_COMP     = 1;
  localparam int WAPUTAG       = 5;
  localparam int NDSFLAGS_MULT = 3;
  localparam int NUSFLAGS_MULT = 8;

  // Bit positions inside the core status word
  localparam int ZERO    = 0;
  localparam int INF     = 1;
  localparam int INVALID = 2;
  localparam int TINY    = 3;
  localparam int HUGE    = 4;
  localparam int INEXACT = 5;

  typedef struct packed {
    logic [FP_WIDTH-1:0]      opa;
    logic [FP_WIDTH-1:0]      opb;
    logic [NDSFLAGS_MULT-1:0] rnd;
    logic [WAPUTAG-1:0]       tag;
  } fp_mult_pre_t;

  typedef struct packed {
    logic [FP_WIDTH-1:0]      res;
    logic [NUSFLAGS_MULT-1:0] status;
    logic [WAPUTAG-1:0]       tag;
  } fp_mult_post_t;

endpackage

// File: rtl/DW_fp_mult.sv
// Behavioural stand-in for the DesignWare DW_fp_mult core (same parameters and
// ports): IEEE multiply with six rounding modes and the 8-bit status word.
module DW_fp_mult
  import apu_package::*;
#(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic [2:0]                   rnd,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status
);

  localparam int M      = sig_width;
  localparam int E      = exp_width;
  localparam int PW     = 2 * M + 2;
  localparam int BIAS   = (1 << (E - 1)) - 1;
  localparam int EMAX_I = (1 << E) - 1;

  logic          sign, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic          g, s, lsb, inc, ovf, ovf_inf;
  logic [M:0]    ma, mb;
  logic [PW-1:0] p, pn;
  logic [2*PW-1:0] wide;
  logic [E+M-1:0]  mag;
  int            lead, be, sh;

  always_comb begin
    z      = '0;
    status = '0;
    sign   = a[E+M] ^ b[E+M];
    zero_a = (a[E+M-1:M] == '0) && ((a[M-1:0] == '0) || (ieee_compliance == 0));
    zero_b = (b[E+M-1:M] == '0) && ((b[M-1:0] == '0) || (ieee_compliance == 0));
    inf_a  = (a[E+M-1:M] == '1) && (a[M-1:0] == '0);
    inf_b  = (b[E+M-1:M] == '1) && (b[M-1:0] == '0);
    nan_a  = (a[E+M-1:M] == '1) && (a[M-1:0] != '0);
    nan_b  = (b[E+M-1:M] == '1) && (b[M-1:0] != '0);
    ma     = {a[E+M-1:M] != '0, a[M-1:0]};
    mb     = {b[E+M-1:M] != '0, b[M-1:0]};
    p      = PW'(ma) * PW'(mb);

    lead = 0;
    for (int i = 0; i < PW; i++) begin
      if (p[i]) lead = i;
    end
    pn = p << (PW - 1 - lead);
    // Denormal operands carry an effective exponent of 1
    be = ((a[E+M-1:M] == '0) ? 1 : int'(a[E+M-1:M]))
       + ((b[E+M-1:M] == '0) ? 1 : int'(b[E+M-1:M])) - BIAS + lead - 2 * M;
    sh = (be < 1) ? (1 - be) : 0;
    if (sh > 2 * PW) sh = 2 * PW;
    wide = {pn, {PW{1'b0}}} >> sh;

    lsb = wide[2*PW-M-1];
    g   = wide[2*PW-M-2];
    s   = |wide[2*PW-M-3:0];
    case (rnd)
      3'd0:    inc = g & (s | lsb);
      3'd1:    inc = 1'b0;
      3'd2:    inc = ~sign & (g | s);
      3'd3:    inc = sign & (g | s);
      3'd4:    inc = g;
      default: inc = g | s;
    endcase
    mag = {(wide[2*PW-1] ? E'(be) : E'(0)), wide[2*PW-2 -: M]} + (E+M)'(inc);
    ovf = (be >= EMAX_I) || (mag[E+M-1:M] == E'(EMAX_I));
    case (rnd)
      3'd1:    ovf_inf = 1'b0;
      3'd2:    ovf_inf = ~sign;
      3'd3:    ovf_inf = sign;
      default: ovf_inf = 1'b1;
    endcase

    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      z               = {1'b0, E'(EMAX_I), 1'b1, (M-1)'(0)};
      status[INVALID] = 1'b1;
    end else if (inf_a || inf_b) begin
      z           = {sign, E'(EMAX_I), M'(0)};
      status[INF] = 1'b1;
    end else if (zero_a || zero_b) begin
      z            = {sign, (E+M)'(0)};
      status[ZERO] = 1'b1;
    end else if (ovf) begin
      status[HUGE]    = 1'b1;
      status[INEXACT] = 1'b1;
      status[INF]     = ovf_inf;
      z = ovf_inf ? {sign, E'(EMAX_I), M'(0)} : {sign, E'(EMAX_I - 1), {M{1'b1}}};
    end else begin
      z               = {sign, mag};
      status[INEXACT] = g | s;
      status[TINY]    = (be < 1);
      status[ZERO]    = (mag == '0);
    end
  end

endmodule

// File: rtl/fp_pipe_stage.sv
// One elastic register stage: valid/ready handshake, payload loads only on an
// upstream transfer and holds under backpressure.
module fp_pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign ready_o = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // NOTE: state updates use non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; the payload is reset too, so outputs read
  // as zero after reset rather than whatever the flops powered up with.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Elastic pipelined FP multiplier around DW_fp_mult with configurable pre/post
// stages. Define FP_MULT_STICKY_STATUS_EN to add the sticky status accumulator.
module fp_mult_pipe
  import apu_package::*;
#(
  parameter int NUM_PRE_REGS  = 1,
  parameter int NUM_POST_REGS = 1,
  parameter int EXP_BITS      = EXP_WIDTH,
  parameter int MAN_BITS      = SIG_WIDTH,
  parameter int TAG_WIDTH     = WAPUTAG,
  parameter int RND_WIDTH     = NDSFLAGS_MULT,
  parameter int STAT_WIDTH    = NUSFLAGS_MULT,
  localparam int FP_BITS      = 1 + EXP_BITS + MAN_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  En_i,
  output logic                  Ready_o,
  input  logic [FP_BITS-1:0]    OpA_i,
  input  logic [FP_BITS-1:0]    OpB_i,
  input  logic [RND_WIDTH-1:0]  Rnd_i,
  input  logic [TAG_WIDTH-1:0]  Tag_i,
  output logic                  Valid_o,
  input  logic                  Ack_i,
  output logic [FP_BITS-1:0]    Res_o,
  output logic [STAT_WIDTH-1:0] Status_o,
  output logic [TAG_WIDTH-1:0]  Tag_o
`ifdef FP_MULT_STICKY_STATUS_EN
  ,
  input  logic                  ClrSticky_i,
  output logic [STAT_WIDTH-1:0] Sticky_o
`endif
);

  logic          pre_valid [NUM_PRE_REGS+1];
  logic          pre_ready [NUM_PRE_REGS+1];
  fp_mult_pre_t  pre_data  [NUM_PRE_REGS+1];
  logic          post_valid[NUM_POST_REGS+1];
  logic          post_ready[NUM_POST_REGS+1];
  fp_mult_post_t post_data [NUM_POST_REGS+1];

  logic               core_valid;
  logic [FP_BITS-1:0] core_opa, core_opb, core_res;
  logic [7:0]         core_status;

  assign pre_valid[0] = En_i;
  assign pre_data[0]  = '{opa: OpA_i, opb: OpB_i, rnd: Rnd_i, tag: Tag_i};
  assign Ready_o      = pre_ready[0];

  for (genvar i = 0; i < NUM_PRE_REGS; i++) begin : g_pre
    fp_pipe_stage #(.WIDTH($bits(fp_mult_pre_t))) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (pre_valid[i]),
      .ready_o (pre_ready[i]),
      .data_i  (pre_data[i]),
      .valid_o (pre_valid[i+1]),
      .ready_i (pre_ready[i+1]),
      .data_o  (pre_data[i+1])
    );
  end

  // Idle core sees zero operands so it does not toggle on stale payload
  assign core_valid = pre_valid[NUM_PRE_REGS];
  assign core_opa   = core_valid ? pre_data[NUM_PRE_REGS].opa : '0;
  assign core_opb   = core_valid ? pre_data[NUM_PRE_REGS].opb : '0;

  DW_fp_mult #(
    .sig_width       (MAN_BITS),
    .exp_width       (EXP_BITS),
    .ieee_compliance (IEEE_COMP)
  ) u_core (
    .a      (core_opa),
    .b      (core_opb),
    .rnd    (pre_data[NUM_PRE_REGS].rnd),
    .z      (core_res),
    .status (core_status)
  );

  assign post_valid[0]            = core_valid;
  assign pre_ready[NUM_PRE_REGS]  = post_ready[0];
  assign post_data[0]             = '{res:    core_res,
                                      status: core_valid ? core_status : '0,
                                      tag:    pre_data[NUM_PRE_REGS].tag};

  for (genvar i = 0; i < NUM_POST_REGS; i++) begin : g_post
    fp_pipe_stage #(.WIDTH($bits(fp_mult_post_t))) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (post_valid[i]),
      .ready_o (post_ready[i]),
      .data_i  (post_data[i]),
      .valid_o (post_valid[i+1]),
      .ready_i (post_ready[i+1]),
      .data_o  (post_data[i+1])
    );
  end

  assign post_ready[NUM_POST_REGS] = Ack_i;
  assign Valid_o  = post_valid[NUM_POST_REGS];
  assign Res_o    = post_data[NUM_POST_REGS].res;
  assign Status_o = post_data[NUM_POST_REGS].status;
  assign Tag_o    = post_data[NUM_POST_REGS].tag;

`ifdef FP_MULT_STICKY_STATUS_EN
  logic [STAT_WIDTH-1:0] sticky_q;
  logic                  out_xfer;

  assign out_xfer = Valid_o & Ack_i;
  assign Sticky_o = sticky_q;

  // A clear coinciding with a transfer keeps that transfer's flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= '0;
    end else if (ClrSticky_i) begin
      sticky_q <= out_xfer ? Status_o : '0;
    end else if (out_xfer) begin
      sticky_q <= sticky_q | Status_o;
    end
  end
`endif

endmodule
